// File: rtl/axis_if.sv
// AXI-Stream beat bundle: {imag, real} data with tlast framing.
// Slave side drives only tready.
interface axis_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_frame_capture.sv
// Frame-aligned capture of FFT output beats into a RAM,
// with 1-cycle registered readback and framing error flags.
module axis_frame_capture #(
  parameter  int WIDTH   = 16,
  parameter  int FFT_LEN = 64,
  parameter  int FRAMES  = 32,
  localparam int DEPTH   = FRAMES * FFT_LEN,
  localparam int AW      = $clog2(DEPTH),
  localparam int IW      = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1,
  localparam int CW      = $clog2(FRAMES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  axis_if.slave              s_axis,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               full,
  output logic               busy,
  output logic [CW-1:0]      frame_cnt,
  output logic               err_tlast_early,
  output logic               err_tlast_missing
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    FULL
  } state_t;

  state_t             state;
  logic               tready_q;
  logic [AW-1:0]      wr_addr;
  logic [IW-1:0]      idx;
  logic [2*WIDTH-1:0] mem [DEPTH];

  logic beat;
  logic we;
  logic idx_end;
  logic addr_end;
  logic wrap;

  assign s_axis.tready = tready_q;
  assign beat     = s_axis.tvalid & tready_q;
  assign we       = beat & ~arm & (state == CAPTURE);
  assign idx_end  = idx == IW'(FFT_LEN - 1);
  assign addr_end = wr_addr == AW'(DEPTH - 1);
  assign wrap     = idx_end | s_axis.tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      tready_q          <= 1'b0;
      wr_addr           <= '0;
      idx               <= '0;
      frame_cnt         <= '0;
      full              <= 1'b0;
      busy              <= 1'b0;
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      // arm wins over any beat arriving in the same cycle
      if (arm) begin
        state             <= ARMED;
        wr_addr           <= '0;
        idx               <= '0;
        frame_cnt         <= '0;
        full              <= 1'b0;
        busy              <= 1'b1;
        err_tlast_early   <= 1'b0;
        err_tlast_missing <= 1'b0;
      end else begin
        unique case (state)
          ARMED: begin
            if (beat && s_axis.tlast)
              state <= CAPTURE;
          end
          CAPTURE: begin
            if (beat) begin
              wr_addr <= wr_addr + 1'b1;
              if (wrap) begin
                idx <= '0;
                if (frame_cnt != '1)
                  frame_cnt <= frame_cnt + 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
              if (s_axis.tlast && !idx_end)
                err_tlast_early <= 1'b1;
              if (idx_end && !s_axis.tlast)
                err_tlast_missing <= 1'b1;
              if (addr_end) begin
                state <= FULL;
                full  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          IDLE, FULL: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Capture RAM is never cleared so old frames stay readable
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= s_axis.tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture, FFT_LEN=8, FRAMES=2.
// Inputs change on negedge; outputs are checked on negedge.
module tb_axis_frame_capture;

  localparam int W  = 16;
  localparam int FL = 8;
  localparam int FR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        busy;
  logic [1:0]  frame_cnt;
  logic        err_early;
  logic        err_missing;

  int n_cmp = 0;
  int n_err = 0;

  axis_if #(.WIDTH(W)) s_axis ();

  axis_frame_capture #(
    .WIDTH   (W),
    .FFT_LEN (FL),
    .FRAMES  (FR)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .arm               (arm),
    .s_axis            (s_axis),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .full              (full),
    .busy              (busy),
    .frame_cnt         (frame_cnt),
    .err_tlast_early   (err_early),
    .err_tlast_missing (err_missing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = l;
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rd_valid", rd_valid, 1);
    chk($sformatf("rd_data[%0d]", a), rd_data, exp);
  endtask

  initial begin
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis.tready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_errs", {err_early, err_missing}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", s_axis.tready, 1);
    chk("post_rst_busy", busy, 0);

    // beat in IDLE is discarded
    send(32'h0000_0EEE, 1'b1);
    chk("idle_busy", busy, 0);

    // aligned capture of 0..15
    pulse_arm();
    chk("armed_busy", busy, 1);
    for (int i = 0; i < 3; i++) send(32'hAA, 1'b0);
    send(32'hBB, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("full_before_last", full, 0);
      send(32'(i), (i == 7) || (i == 15));
    end
    chk("full_set", full, 1);
    chk("full_busy", busy, 0);
    chk("full_frame_cnt", frame_cnt, 2);
    chk("full_errs", {err_early, err_missing}, 0);

    // streaming on after full: discarded, never back-pressured
    s_axis.tdata  = 32'hDEAD;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis.tlast = (i == 2);
      @(negedge clk);
      chk("full_tready", s_axis.tready, 1);
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    chk("full_hold", full, 1);
    rd(4'd5, 32'd5);
    @(negedge clk);
    chk("rd_valid_drop", rd_valid, 0);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'(i));

    // framing errors and read-first collision
    pulse_arm();
    chk("arm_clears_full", full, 0);
    send(32'h0, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), i == 3);
    chk("early_set", err_early, 1);
    chk("early_no_missing", err_missing, 0);
    chk("early_frame_cnt", frame_cnt, 1);
    s_axis.tdata  = 32'h104;
    s_axis.tvalid = 1'b1;
    rd_en         = 1'b1;
    rd_addr       = 4'd4;
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    rd_en         = 1'b0;
    chk("rw_collide_valid", rd_valid, 1);
    chk("rw_collide_old", rd_data, 32'd4);
    for (int i = 5; i < 11; i++) send(32'h100 + 32'(i), 1'b0);
    chk("missing_not_yet", err_missing, 0);
    send(32'h10B, 1'b0);
    chk("missing_set", err_missing, 1);
    chk("early_sticky", err_early, 1);
    chk("missing_frame_cnt", frame_cnt, 2);
    chk("missing_busy", busy, 1);
    rd(4'd4, 32'h104);
    rd(4'd3, 32'h103);
    rd(4'd12, 32'd12);

    // arm mid-capture with a simultaneous beat
    pulse_arm();
    send(32'h0, 1'b1);
    for (int i = 0; i < 6; i++) send(32'h200 + 32'(i), i == 2);
    chk("pre_arm_early", err_early, 1);
    arm           = 1'b1;
    s_axis.tdata  = 32'h2FF;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    arm           = 1'b0;
    s_axis.tvalid = 1'b0;
    chk("rearm_busy", busy, 1);
    chk("rearm_full", full, 0);
    chk("rearm_frame_cnt", frame_cnt, 0);
    chk("rearm_errs", {err_early, err_missing}, 0);
    rd(4'd6, 32'h106);
    send(32'h3AA, 1'b0);
    send(32'h3BB, 1'b1);
    send(32'h300, 1'b0);
    rd(4'd0, 32'h300);
    rd(4'd1, 32'h201);

    // reset mid-capture at wr_addr 10
    for (int i = 1; i < 10; i++) send(32'h300 + 32'(i), i == 7);
    chk("pre_rst_frame_cnt", frame_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_tready", s_axis.tready, 0);
    chk("mid_rst_rd", {rd_valid, rd_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tready", s_axis.tready, 1);
    send(32'h4A0, 1'b1);
    send(32'h4A1, 1'b0);
    send(32'h4A2, 1'b0);
    chk("rel_busy", busy, 0);
    rd(4'd10, 32'h10A);
    rd(4'd0, 32'h300);
    rd(4'd8, 32'h308);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_frame_capture.md
AXIS_FRAME_CAPTURE -- requirements
Module: axis_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16: real/imag component width; a beat is 2*WIDTH bits.
REQ-002 SHALL have parameter FFT_LEN, default 64: beats per frame.
REQ-003 SHALL have parameter FRAMES, default 32: frames captured; DEPTH = FRAMES*FFT_LEN words (derived, not overridable).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port arm, input, 1: single-cycle request to start or restart a capture.
REQ-007 SHALL have port s_axis_tdata, input, 2*WIDTH: OSPFB/FFT output beat, {imag, real}.
REQ-008 SHALL have port s_axis_tvalid, input, 1: beat valid.
REQ-009 SHALL have port s_axis_tready, output, 1: beat accepted.
REQ-010 SHALL have port s_axis_tlast, input, 1: last beat of a frame.
REQ-011 SHALL have port rd_en, input, 1: readback request.
REQ-012 SHALL have port rd_addr, input, $clog2(DEPTH): readback word address.
REQ-013 SHALL have port rd_data, output, 2*WIDTH: readback word.
REQ-014 SHALL have port rd_valid, output, 1: rd_data valid.
REQ-015 SHALL have port full, output, 1: DEPTH words captured.
REQ-016 SHALL have port busy, output, 1: in ARMED or CAPTURE.
REQ-017 SHALL have port frame_cnt, output, $clog2(FRAMES+1): completed frames in the current capture.
REQ-018 SHALL have port err_tlast_early, output, 1: sticky; tlast arrived before beat FFT_LEN-1.
REQ-019 SHALL have port err_tlast_missing, output, 1: sticky; beat FFT_LEN-1 arrived without tlast.

Function
REQ-020 SHALL implement states IDLE, ARMED, CAPTURE, FULL.
REQ-021 SHALL drive s_axis_tready from a register that is 1 in every state after reset; beats are never back-pressured and are discarded outside CAPTURE.
REQ-022 IDLE: arm SHALL move the block to ARMED.
REQ-023 ARMED: an accepted beat with tlast=1 SHALL move the block to CAPTURE; that beat SHALL NOT be stored, so capture starts frame-aligned.
REQ-024 CAPTURE: each accepted beat SHALL be written to RAM[wr_addr], and wr_addr and the in-frame index SHALL then increment.
REQ-025 On accepted tlast at index < FFT_LEN-1, the block SHALL set err_tlast_early and reset the index to 0; wr_addr continues with no gap.
REQ-026 On accepted beat at index FFT_LEN-1 without tlast, the block SHALL set err_tlast_missing and wrap the index to 0.
REQ-027 frame_cnt SHALL increment on every index wrap or reset.
REQ-028 Writing wr_addr = DEPTH-1 SHALL enter FULL, with full=1 on the next cycle.
REQ-029 FULL: the block SHALL accept and discard beats; full SHALL hold until arm.
REQ-030 arm in ARMED, CAPTURE or FULL SHALL restart: clear wr_addr, index, frame_cnt, full and both errors, and go to ARMED.
REQ-031 arm SHALL take priority over a simultaneous beat; that beat SHALL be discarded.
REQ-032 Readback SHALL be legal in every state, with 1-cycle latency: rd_valid = rd_en delayed 1 cycle, rd_data = RAM[rd_addr] registered.
REQ-033 A read and a write to the same address in the same cycle SHALL return the old contents (read-first).
REQ-034 RAM contents SHALL NOT be cleared by reset or arm.

Reset
REQ-035 While rst_n=0, the block SHALL hold state IDLE, s_axis_tready=0, rd_valid=0, rd_data=0, full=0, busy=0, frame_cnt=0 and both errors 0.
REQ-036 Reset asserted mid-capture SHALL abort immediately; after release the block SHALL be in IDLE with s_axis_tready=1 on the first clk edge.

Verification
REQ-037 Scenario: FFT_LEN=8, FRAMES=2, arm, 3 beats without tlast, then one beat with tlast, then 16 beats with data 0..15 and tlast on beats 7 and 15 -> RAM[0..15] = 0..15, full=1 one cycle after the 16th beat, frame_cnt=2, no errors.
REQ-038 Scenario: continuous tvalid after full -> RAM unchanged, tready stays 1; a later rd_en at address 5 -> rd_valid and rd_data=5 on the next cycle.
REQ-039 Scenario: tlast at index 3 within CAPTURE -> err_tlast_early=1 and the next beat starts frame 1; index 7 without tlast -> err_tlast_missing=1; both remain set until arm.
REQ-040 Scenario: arm pulsed mid-capture at wr_addr=6 together with a valid beat -> beat dropped, full=0, frame_cnt=0, errors cleared, state ARMED; next aligned capture overwrites from address 0.
REQ-041 Scenario: rst_n low for 1 cycle at wr_addr=10 -> outputs at reset values immediately; after release no writes occur until arm plus tlast alignment.
REQ-042 Scenario: read and write to address 4 in the same cycle -> rd_data returns the previous contents; a re-read returns the new value.
